// File: rtl/dm_pkg.sv
// Shared codes and sizing for the data-memory responder.
package dm_pkg;

    localparam int unsigned DM_WORDS = 1024;
    localparam int unsigned DM_AW    = 10;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    localparam logic [1:0] ST_WORD = 2'd0;
    localparam logic [1:0] ST_HALF = 2'd1;
    localparam logic [1:0] ST_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ACC_WORD,
        ACC_HALF,
        ACC_BYTE
    } acc_width_t;

    // Out-of-range size/type codes fall back to word access.
    function automatic acc_width_t access_width(input logic       wr,
                                                input logic [1:0] sz,
                                                input logic [2:0] lt);
        acc_width_t w;
        w = ACC_WORD;
        if (wr) begin
            if (sz == ST_HALF)      w = ACC_HALF;
            else if (sz == ST_BYTE) w = ACC_BYTE;
        end else begin
            if (lt == LT_LH || lt == LT_LHU)      w = ACC_HALF;
            else if (lt == LT_LB || lt == LT_LBU) w = ACC_BYTE;
        end
        return w;
    endfunction

    function automatic logic access_misaligned(input acc_width_t w, input logic [1:0] off);
        return ((w == ACC_WORD) && (off != 2'b00)) || ((w == ACC_HALF) && off[0]);
    endfunction

endpackage

// File: rtl/dm_ext.sv
// Combinational lane logic: load extraction/extension and store byte-enable/alignment.
module dm_ext
    import dm_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [2:0]  load_type,
    input  logic [31:0] raw_word,
    input  logic [1:0]  st_size,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte  = raw_word[{byte_off, 3'b000} +: 8];
        sel_half  = raw_word[{byte_off[1], 4'b0000} +: 16];
        load_data = raw_word;
        case (load_type)
            LT_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            LT_LHU:  load_data = {16'h0000, sel_half};
            LT_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            LT_LBU:  load_data = {24'h000000, sel_byte};
            default: load_data = raw_word;
        endcase
    end

    // Replicating the datum lets the byte enables alone pick the lane.
    always_comb begin
        byte_en    = 4'b1111;
        store_data = wdata;
        case (st_size)
            ST_HALF: begin
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            ST_BYTE: begin
                byte_en    = 4'b0001 << byte_off;
                store_data = {4{wdata[7:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// 4 KiB data memory responder with registered W-stage load result.
// Optional DM_WAIT_STATE_EN inserts one wait state per request (IDLE/WAIT FSM).
module dm_responder
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_write,
    input  logic [1:0]  st_size,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_w,
    output logic        rvalid_w,
    output logic        misalign_w,
    output logic        stall
);

    logic [31:0]      mem [DM_WORDS];
    logic [DM_AW-1:0] idx;
    logic [31:0]      raw_word;
    logic [31:0]      load_data;
    logic [3:0]       byte_en;
    logic [31:0]      store_data;
    logic             complete;
    logic             misaligned;
    logic             unused_addr_hi;

    assign idx            = addr[DM_AW+1:2];
    assign raw_word       = mem[idx];
    assign unused_addr_hi = &{1'b0, addr[31:DM_AW+2]};
    assign misaligned     = access_misaligned(access_width(mem_write, st_size, load_type), addr[1:0]);

`ifdef DM_WAIT_STATE_EN
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0] state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (req_valid) state <= S_WAIT;
                S_WAIT:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Requester holds its inputs through WAIT, so the live inputs are the request.
    assign stall    = (state == S_IDLE) && req_valid;
    assign complete = (state == S_WAIT);
`else
    assign stall    = 1'b0;
    assign complete = req_valid;
`endif

    dm_ext u_ext (
        .byte_off   (addr[1:0]),
        .load_type  (load_type),
        .raw_word   (raw_word),
        .st_size    (st_size),
        .wdata      (wdata),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .store_data (store_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                mem[DM_AW'(i)] <= '0;
            end
        end else if (complete && mem_write && !misaligned) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_w    <= '0;
            rvalid_w   <= 1'b0;
            misalign_w <= 1'b0;
        end else begin
            rvalid_w   <= complete && !mem_write && !misaligned;
            misalign_w <= complete && misaligned;
            rdata_w    <= (complete && !mem_write && !misaligned) ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder; adapts to DM_WAIT_STATE_EN.
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        mem_write;
    logic [1:0]  st_size;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_w;
    logic        rvalid_w;
    logic        misalign_w;
    logic        stall;

    int checks;
    int errors;

`ifdef DM_WAIT_STATE_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 0;
`endif

    dm_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .mem_write  (mem_write),
        .st_size    (st_size),
        .load_type  (load_type),
        .addr       (addr),
        .wdata      (wdata),
        .rdata_w    (rdata_w),
        .rvalid_w   (rvalid_w),
        .misalign_w (misalign_w),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request, holds it while stalled, returns after the completing edge (+1).
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic [2:0] lt,
                          input logic [31:0] a, input logic [31:0] wd, output int n_stall);
        req_valid = 1'b1;
        mem_write = wr;
        st_size   = sz;
        load_type = lt;
        addr      = a;
        wdata     = wd;
        n_stall   = 0;
        #1;
        while (stall === 1'b1 && n_stall < 4) begin
            @(posedge clk); #1;
            n_stall++;
        end
        checks++;
        if (n_stall >= 4) begin
            errors++;
            $display("FAIL stall_timeout: stall cycles %0d, required < 4", n_stall);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (stall !== 1'b0 || rvalid_w !== 1'b0 || misalign_w !== 1'b0 || rdata_w !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b rvalid=%b mis=%b rdata=%h, required 0/0/0/00000000",
                     stall, rvalid_w, misalign_w, rdata_w);
        end
        reset = 1'b0;
    endtask

    task automatic test_word;
        int n;
        do_req(1'b1, 2'd0, 3'd0, 32'h10, 32'h12345678, n);
        checks++;
        if (n !== EXP_STALL) begin
            errors++;
            $display("FAIL sw_stall_cycles: got %0d, required %0d", n, EXP_STALL);
        end
        checks++;
        if (rvalid_w !== 1'b0 || rdata_w !== 32'h0 || misalign_w !== 1'b0) begin
            errors++;
            $display("FAIL sw_result: rvalid=%b rdata=%h mis=%b, required 0/00000000/0", rvalid_w, rdata_w, misalign_w);
        end
        do_req(1'b0, 2'd0, 3'd0, 32'h10, 32'h0, n);
        checks++;
        if (rvalid_w !== 1'b1 || rdata_w !== 32'h12345678) begin
            errors++;
            $display("FAIL lw_0x10: rvalid=%b rdata=%h, required 1/12345678", rvalid_w, rdata_w);
        end
    endtask

    task automatic test_idle;
        @(posedge clk); #1;
        checks++;
        if (rvalid_w !== 1'b0 || misalign_w !== 1'b0 || rdata_w !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs: rvalid=%b mis=%b rdata=%h, required 0/0/00000000", rvalid_w, misalign_w, rdata_w);
        end
    endtask

    task automatic test_byte;
        int n;
        do_req(1'b1, 2'd2, 3'd0, 32'h13, 32'h123456AB, n);
        do_req(1'b0, 2'd0, 3'd0, 32'h10, 32'h0, n);
        checks++;
        if (rdata_w !== 32'hAB345678) begin
            errors++;
            $display("FAIL sb_then_lw: rdata=%h, required ab345678", rdata_w);
        end
        do_req(1'b0, 2'd0, 3'd3, 32'h13, 32'h0, n);
        checks++;
        if (rdata_w !== 32'hFFFFFFAB) begin
            errors++;
            $display("FAIL lb_0x13: rdata=%h, required ffffffab", rdata_w);
        end
        do_req(1'b0, 2'd0, 3'd4, 32'h13, 32'h0, n);
        checks++;
        if (rdata_w !== 32'h000000AB) begin
            errors++;
            $display("FAIL lbu_0x13: rdata=%h, required 000000ab", rdata_w);
        end
        do_req(1'b0, 2'd0, 3'd3, 32'h12, 32'h0, n);
        checks++;
        if (rdata_w !== 32'h00000034) begin
            errors++;
            $display("FAIL lb_0x12: rdata=%h, required 00000034", rdata_w);
        end
        do_req(1'b0, 2'd0, 3'd7, 32'h10, 32'h0, n);
        checks++;
        if (rvalid_w !== 1'b1 || rdata_w !== 32'hAB345678) begin
            errors++;
            $display("FAIL lt7_as_lw: rvalid=%b rdata=%h, required 1/ab345678", rvalid_w, rdata_w);
        end
    endtask

    task automatic test_half;
        int n;
        do_req(1'b1, 2'd1, 3'd0, 32'h22, 32'h55558001, n);
        do_req(1'b0, 2'd0, 3'd1, 32'h22, 32'h0, n);
        checks++;
        if (rdata_w !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh_0x22: rdata=%h, required ffff8001", rdata_w);
        end
        do_req(1'b0, 2'd0, 3'd2, 32'h22, 32'h0, n);
        checks++;
        if (rdata_w !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu_0x22: rdata=%h, required 00008001", rdata_w);
        end
        do_req(1'b0, 2'd0, 3'd0, 32'h20, 32'h0, n);
        checks++;
        if (rdata_w !== 32'h80010000) begin
            errors++;
            $display("FAIL lw_0x20: rdata=%h, required 80010000", rdata_w);
        end
        do_req(1'b0, 2'd0, 3'd1, 32'h20, 32'h0, n);
        checks++;
        if (rdata_w !== 32'h00000000) begin
            errors++;
            $display("FAIL lh_0x20: rdata=%h, required 00000000", rdata_w);
        end
    endtask

    task automatic test_misalign;
        int n;
        do_req(1'b1, 2'd0, 3'd0, 32'h11, 32'hCAFEF00D, n);
        checks++;
        if (misalign_w !== 1'b1 || rvalid_w !== 1'b0) begin
            errors++;
            $display("FAIL sw_0x11_misalign: mis=%b rvalid=%b, required 1/0", misalign_w, rvalid_w);
        end
        do_req(1'b0, 2'd0, 3'd0, 32'h10, 32'h0, n);
        checks++;
        if (misalign_w !== 1'b0 || rdata_w !== 32'hAB345678) begin
            errors++;
            $display("FAIL word_0x10_unchanged: mis=%b rdata=%h, required 0/ab345678", misalign_w, rdata_w);
        end
        do_req(1'b0, 2'd0, 3'd1, 32'h21, 32'h0, n);
        checks++;
        if (misalign_w !== 1'b1 || rvalid_w !== 1'b0 || rdata_w !== 32'h0) begin
            errors++;
            $display("FAIL lh_0x21_misalign: mis=%b rvalid=%b rdata=%h, required 1/0/00000000",
                     misalign_w, rvalid_w, rdata_w);
        end
        do_req(1'b1, 2'd3, 3'd0, 32'h22, 32'h77777777, n);
        checks++;
        if (misalign_w !== 1'b1) begin
            errors++;
            $display("FAIL sz3_word_misalign: mis=%b, required 1", misalign_w);
        end
    endtask

    task automatic test_wrap;
        int n;
        do_req(1'b1, 2'd0, 3'd0, 32'h1004, 32'hDEADBEEF, n);
        do_req(1'b0, 2'd0, 3'd0, 32'h0004, 32'h0, n);
        checks++;
        if (rvalid_w !== 1'b1 || rdata_w !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wrap_lw_0x4: rvalid=%b rdata=%h, required 1/deadbeef", rvalid_w, rdata_w);
        end
    endtask

`ifdef DM_WAIT_STATE_EN
    task automatic test_wait_state;
        int n;
        req_valid = 1'b1; mem_write = 1'b0; st_size = 2'd0; load_type = 3'd0; addr = 32'h20; wdata = 32'h0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall_first: stall=%b, required 1", stall);
        end
        @(posedge clk); #1;
        checks++;
        if (stall !== 1'b0 || rvalid_w !== 1'b0) begin
            errors++;
            $display("FAIL wait_stall_second: stall=%b rvalid=%b, required 0/0", stall, rvalid_w);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rvalid_w !== 1'b1 || rdata_w !== 32'h80010000) begin
            errors++;
            $display("FAIL wait_lw_result: rvalid=%b rdata=%h, required 1/80010000", rvalid_w, rdata_w);
        end
        // Store interrupted by reset during WAIT must not land.
        req_valid = 1'b1; mem_write = 1'b1; st_size = 2'd0; addr = 32'h30; wdata = 32'h11111111;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (stall !== 1'b0 || rvalid_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: stall=%b rvalid=%b, required 0/0", stall, rvalid_w);
        end
        do_req(1'b0, 2'd0, 3'd0, 32'h30, 32'h0, n);
        checks++;
        if (rdata_w !== 32'h0) begin
            errors++;
            $display("FAIL dropped_store_0x30: rdata=%h, required 00000000", rdata_w);
        end
    endtask
`endif

    task automatic test_reset_clears;
        int n;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        do_req(1'b0, 2'd0, 3'd0, 32'h10, 32'h0, n);
        checks++;
        if (rvalid_w !== 1'b1 || rdata_w !== 32'h0) begin
            errors++;
            $display("FAIL reset_clears_mem: rvalid=%b rdata=%h, required 1/00000000", rvalid_w, rdata_w);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; req_valid = 1'b0; mem_write = 1'b0;
        st_size = 2'd0; load_type = 3'd0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_word;
        test_idle;
        test_byte;
        test_half;
        test_misalign;
        test_wrap;
`ifdef DM_WAIT_STATE_EN
        test_wait_state;
`endif
        test_reset_clears;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL have the port `clk  in  1`: clock; all state updates on rising edge.
REQ-002 The block SHALL have the port `reset  in  1`: reset, synchronous, active-high.
REQ-003 The block SHALL have the port `req_valid  in  1`: M-stage memory request present this cycle.
REQ-004 The block SHALL have the port `mem_write  in  1`: 1 = store, 0 = load; sampled only with req_valid.
REQ-005 The block SHALL have the port `st_size  in  2`: store size; 0 word, 1 half, 2 byte; 3 treated as word.
REQ-006 The block SHALL have the port `load_type  in  3`: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu; 5-7 treated as lw.
REQ-007 The block SHALL have the port `addr  in  32`: byte address.
REQ-008 The block SHALL have the port `wdata  in  32`: store data, right-aligned.
REQ-009 The block SHALL have the port `rdata_w  out  32`: W-stage load result, extended.
REQ-010 The block SHALL have the port `rvalid_w  out  1`: rdata_w holds a completed load.
REQ-011 The block SHALL have the port `misalign_w  out  1`: the completed request was misaligned.
REQ-012 The block SHALL have the port `stall  out  1`: hold the M stage; request is not yet complete.

Function
REQ-013 Storage SHALL be 1024 x 32-bit words, indexed by addr[11:2]; addr[31:12] ignored (wrap at 4 KiB).
REQ-014 A store SHALL write on the completing rising edge using byte enables: word -> 4'b1111; half -> lanes {addr[1],0} and {addr[1],1}; byte -> lane addr[1:0].
REQ-015 Store data SHALL be lane-aligned: half -> wdata[15:0] placed in the selected half; byte -> wdata[7:0] placed in the selected byte; unselected bytes unchanged.
REQ-016 A load SHALL read the addressed word, select the lane by addr[1:0], and sign- or zero-extend per load_type; the result is registered into rdata_w.
REQ-017 Load latency SHALL be 1 cycle from completion: rvalid_w=1 and rdata_w valid in the cycle after the completing edge.
REQ-018 For a store, rvalid_w SHALL be 0 and rdata_w SHALL be 0 after completion.
REQ-019 Misalignment SHALL be detected as word with addr[1:0]!=0, or half with addr[0]!=0.
REQ-020 On a misaligned request, the write SHALL be suppressed, misalign_w=1, rdata_w=0, and rvalid_w=0, all for one cycle.
REQ-021 A load in the cycle after a store to the same word SHALL return the newly written data (no bypass needed; write precedes read).
REQ-022 When req_valid=0, the next cycle SHALL have rvalid_w=0, misalign_w=0, and rdata_w=0.

Reset
REQ-023 On reset, rdata_w, rvalid_w, misalign_w, and stall SHALL be 0, and the FSM (if present) SHALL be IDLE.
REQ-024 All 1024 words SHALL be cleared to 0 on reset.
REQ-025 A request in flight when reset asserts SHALL be dropped, with no write.

Configuration
REQ-026 The block SHALL support macro DM_WAIT_STATE_EN.
- Defined: a 2-state FSM (IDLE, WAIT).
  - IDLE + req_valid -> WAIT, with stall=1 combinationally that cycle and no write.
  - WAIT -> IDLE: the request completes (write or read) on that edge, with stall=0 in WAIT.
  - The requester SHALL hold its inputs while stall=1.
  - Effective latency: load data appears 2 cycles after first presentation.
- Undefined: the FSM is absent, stall is tied to 0, and every request completes on its first edge.

Structure
REQ-027 Package dm_pkg SHALL hold load_type codes, st_size codes, DM_WORDS=1024, and DM_AW=10.
REQ-028 Sub-module dm_ext SHALL be combinational: addr[1:0] plus load_type plus raw word -> extended data; addr[1:0] plus st_size -> byte enables and aligned store data.

Verification
REQ-029 The bench SHALL cover: sw 0x12345678 @0x10, then lw @0x10 -> next cycle rvalid_w=1, rdata_w=0x12345678.
REQ-030 The bench SHALL cover: sb 0xAB @0x13 over 0x12345678, then lw @0x10 -> 0xAB345678; lb @0x13 -> 0xFFFFFFAB; lbu @0x13 -> 0x000000AB.
REQ-031 The bench SHALL cover: sh 0x8001 @0x22, then lh @0x22 -> 0xFFFF8001; lhu @0x22 -> 0x00008001; lw @0x20 -> 0x80010000.
REQ-032 The bench SHALL cover: sw @0x11 -> misalign_w=1, and word 0x10 is unchanged; lh @0x21 -> misalign_w=1, rvalid_w=0.
REQ-033 The bench SHALL cover address wrap: sw 0xDEADBEEF @0x1004, then lw @0x0004 -> 0xDEADBEEF.
REQ-034 The bench SHALL cover: with DM_WAIT_STATE_EN, lw held 2 cycles -> stall=1,0, then rvalid_w=1; reset asserted during WAIT on a store -> memory word unchanged, stall=0.
